lookahead_limiter: RTL and testbench

Output-stage peak limiter placed directly downstream of frequency_machine, consuming its 24-bit crossfaded data_o. It protects the DAC path from the gain boosts that the wet path introduces (the x4 filtered side and the oscillator recovery). A LOOKAHEAD-sample delay line lets gain reduction land before the peak reaches the output. Gain is computed per sample by a serial divider, applied by one multiplier, and released linearly after a hold period.

---
 rtl/lookahead_limiter_pkg.sv | 21 ++
 rtl/lookahead_limiter_if.sv | 28 ++
 rtl/lookahead_limiter_serial_divider.sv | 64 ++++++
 rtl/lookahead_limiter.sv | 201 ++++++++++++++++++++
 tb/tb_lookahead_limiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lookahead_limiter_pkg.sv
// Shared constants and types for the lookahead peak limiter.
package limiter_pkg;

  // Gain is unsigned Q1.15, so unity sits at the top bit.
  localparam int GW       = 16;
  localparam int PIPE_LAT = GW + 4;

  typedef logic [GW-1:0] gain_t;

  localparam gain_t UNITY = {1'b1, {(GW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DIV,
    GAIN,
    MULT,
    OUT
  } state_t;

endpackage

// File: rtl/lookahead_limiter_if.sv
// Sample-stream and status bundle between the upstream mixer and the limiter.
interface lookahead_limiter_if #(
  parameter int DW = 24
);
  import limiter_pkg::*;

  logic                 sample_tick_i;
  logic signed [DW-1:0] data_i;
  logic                 enable_i;
  logic [7:0]           threshold_i;
  logic [7:0]           release_i;
  logic signed [DW-1:0] data_o;
  logic                 sample_tick_o;
  gain_t                gain_o;
  logic                 limiting_o;
  logic                 overrun_o;

  modport master (
    output sample_tick_i, data_i, enable_i, threshold_i, release_i,
    input  data_o, sample_tick_o, gain_o, limiting_o, overrun_o
  );

  modport slave (
    input  sample_tick_i, data_i, enable_i, threshold_i, release_i,
    output data_o, sample_tick_o, gain_o, limiting_o, overrun_o
  );

endinterface

// File: rtl/lookahead_limiter_serial_divider.sv
// Restoring unsigned divider producing one quotient bit per clock.
// The dividend is {num_hi, num_lo}; num_hi must be below den so the
// quotient fits in QW bits. done is high during the final step, and
// quot holds the result from the following cycle on.
module serial_divider #(
  parameter int QW  = 16,
  parameter int DVW = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DVW-1:0] num_hi,
  input  logic [QW-1:0]  num_lo,
  input  logic [DVW-1:0] den,
  output logic [QW-1:0]  quot,
  output logic           done
);

  localparam int CNTW = $clog2(QW + 1);

  logic [DVW-1:0]  rem_q;
  logic [DVW-1:0]  den_q;
  logic [QW-1:0]   shift_q;
  logic [CNTW-1:0] cnt_q;
  logic            busy_q;
  logic [DVW:0]    partial;
  logic [DVW-1:0]  diff;
  logic            fits;

  // One restoring step: shift the next dividend bit into the remainder and try the subtraction.
  always_comb begin
    partial = {rem_q, shift_q[QW-1]};
    diff    = partial[DVW-1:0] - den_q;
    fits    = (partial >= {1'b0, den_q});
  end

  assign done = busy_q && (cnt_q == CNTW'(1));
  assign quot = shift_q;

  // Load operands on start, then retire one quotient bit per cycle for QW cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      den_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      rem_q   <= num_hi;
      den_q   <= den;
      shift_q <= num_lo;
      cnt_q   <= CNTW'(QW);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      rem_q   <= fits ? diff : partial[DVW-1:0];
      shift_q <= {shift_q[QW-2:0], fits};
      cnt_q   <= cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lookahead_limiter.sv
// Output-stage peak limiter. Each sample is written into a LOOKAHEAD-deep
// delay line while its gain target is computed, so gain reduction reaches
// the output before the peak itself does. Gain recovers linearly after a
// hold of LOOKAHEAD ticks. Every accepted tick takes a fixed path through
// the FSM and produces one output tick PIPE_LAT clocks later.
module lookahead_limiter
  import limiter_pkg::*;
#(
  parameter int DW        = 24,
  parameter int LOOKAHEAD = 16
) (
  input  logic               clk_i,
  input  logic               srst_i,
  lookahead_limiter_if.slave bus
);

  localparam int AW = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1;
  localparam int CW = AW + 1;
  localparam int PW = DW + GW + 1;

  localparam logic [CW-1:0]        LA_CNT   = CW'(LOOKAHEAD);
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [DW-1:0]        ONE_D    = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]        NEG_FULL = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        POS_FULL = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] Y_MAX    = {{(GW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] Y_MIN    = {{(GW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] ROUND    = {{(DW+2){1'b0}}, 1'b1, {(GW-2){1'b0}}};

  state_t               state;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        fill_cnt;
  logic [CW-1:0]        hold_cnt;
  logic signed [DW-1:0] sample_q;
  logic signed [DW-1:0] delayed_q;
  logic signed [DW-1:0] y_q;
  logic                 zero_out_q;
  logic                 need_div_q;
  logic [7:0]           rel_q;
  gain_t                gain_q;

  logic signed [DW-1:0] delay_mem [LOOKAHEAD];

  logic [DW-1:0]        abs_val;
  logic [7:0]           thr_eff;
  logic [DW-1:0]        thr_val;
  logic                 div_start;
  logic                 div_done;
  gain_t                div_quot;
  gain_t                target;
  logic [GW:0]          rel_sum;
  gain_t                rel_gain;
  logic signed [PW-1:0] d_ext;
  logic signed [PW-1:0] g_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;
  logic signed [DW-1:0] y_next;

  // Magnitude of the captured sample; the most negative code clamps to full scale.
  always_comb begin
    abs_val = sample_q;
    if (sample_q == NEG_FULL) begin
      abs_val = POS_FULL;
    end else if (sample_q[DW-1]) begin
      abs_val = ~sample_q + ONE_D;
    end
  end

  // Threshold level aligned to the sample scale; a zero setting behaves as one.
  always_comb begin
    thr_eff = (bus.threshold_i == 8'd0) ? 8'd1 : bus.threshold_i;
    thr_val = {{(DW-8){1'b0}}, thr_eff} << (GW - 1);
  end

  assign div_start = (state == CAPTURE);

  // T * 2^(GW-1) / abs is computed as (T/2) * 2^GW / abs, which keeps the
  // high dividend word below the divisor whenever the result is used.
  serial_divider #(
    .QW  (GW),
    .DVW (DW)
  ) u_div (
    .clk    (clk_i),
    .rst    (srst_i),
    .start  (div_start),
    .num_hi (thr_val >> 1),
    .num_lo ('0),
    .den    (abs_val),
    .quot   (div_quot),
    .done   (div_done)
  );

  // Gain target and linear release step, capped at unity.
  always_comb begin
    target   = need_div_q ? div_quot : UNITY;
    rel_sum  = {1'b0, gain_q} + {{(GW-7){1'b0}}, rel_q};
    rel_gain = (rel_sum > {1'b0, UNITY}) ? UNITY : rel_sum[GW-1:0];
  end

  // Rounded Q1.15 scaling of the delayed sample, saturated to the sample width.
  always_comb begin
    d_ext   = {{(GW+1){delayed_q[DW-1]}}, delayed_q};
    g_ext   = {{(DW+1){1'b0}}, gain_q};
    prod    = d_ext * g_ext + ROUND;
    prod_sh = prod >>> (GW - 1);
    if (prod_sh > Y_MAX) begin
      y_next = Y_MAX[DW-1:0];
    end else if (prod_sh < Y_MIN) begin
      y_next = Y_MIN[DW-1:0];
    end else begin
      y_next = prod_sh[DW-1:0];
    end
  end

  // Delay line: read the oldest sample and overwrite it with the new one in CAPTURE.
  always_ff @(posedge clk_i) begin
    if (state == CAPTURE) begin
      delayed_q         <= delay_mem[wr_ptr];
      delay_mem[wr_ptr] <= sample_q;
    end
  end

  // Sequencer for one sample: capture, divide, update gain, scale, publish.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      fill_cnt          <= '0;
      hold_cnt          <= '0;
      sample_q          <= '0;
      y_q               <= '0;
      zero_out_q        <= 1'b1;
      need_div_q        <= 1'b0;
      rel_q             <= '0;
      gain_q            <= UNITY;
      bus.data_o        <= '0;
      bus.sample_tick_o <= 1'b0;
      bus.gain_o        <= UNITY;
      bus.limiting_o    <= 1'b0;
      bus.overrun_o     <= 1'b0;
    end else begin
      bus.sample_tick_o <= 1'b0;
      if (bus.sample_tick_i && (state != IDLE)) begin
        bus.overrun_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.sample_tick_i) begin
            sample_q <= bus.data_i;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          wr_ptr     <= wr_ptr + PTR_ONE;
          zero_out_q <= (fill_cnt != LA_CNT);
          if (fill_cnt != LA_CNT) begin
            fill_cnt <= fill_cnt + CNT_ONE;
          end
          need_div_q <= (abs_val > thr_val);
          rel_q      <= bus.release_i;
          state      <= DIV;
        end
        DIV: begin
          if (div_done) begin
            state <= GAIN;
          end
        end
        GAIN: begin
          if (!bus.enable_i) begin
            gain_q   <= UNITY;
            hold_cnt <= '0;
          end else if (target < gain_q) begin
            gain_q   <= target;
            hold_cnt <= LA_CNT;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CNT_ONE;
          end else begin
            gain_q <= rel_gain;
          end
          state <= MULT;
        end
        MULT: begin
          y_q   <= y_next;
          state <= OUT;
        end
        OUT: begin
          bus.data_o        <= zero_out_q ? '0 : y_q;
          bus.sample_tick_o <= 1'b1;
          bus.gain_o        <= gain_q;
          bus.limiting_o    <= (gain_q < UNITY);
          state             <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lookahead_limiter.sv
// Self-checking bench for lookahead_limiter: a behavioural model predicts
// each output into a scoreboard queue, and a monitor compares on sample_tick_o.
module tb_lookahead_limiter;

  typedef struct {
    logic [23:0] data;
    logic [15:0] gain;
    logic        lim;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  exp_t   sb [$];
  exp_t   mon_e;
  longint m_mem [16];
  int     m_ptr;
  int     m_fill;
  int     m_hold;
  longint m_gain;

  lookahead_limiter_if #(.DW(24)) bus ();

  lookahead_limiter #(
    .DW        (24),
    .LOOKAHEAD (16)
  ) dut (
    .clk_i  (clk),
    .srst_i (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_ptr  = 0;
    m_fill = 0;
    m_hold = 0;
    m_gain = 32768;
  endtask

  // Reference behaviour of one accepted tick, pushed as an expected output.
  task automatic modelPush(input logic signed [23:0] d, input logic en, input logic [7:0] thr,
                           input logic [7:0] rel, input int tcyc);
    longint dv, absv, t, target, delayed, y;
    logic   zero;
    exp_t   e;
    dv   = longint'(d);
    absv = (dv == -64'sd8388608) ? 64'sd8388607 : ((dv < 0) ? -dv : dv);
    t    = longint'((thr == 8'd0) ? 8'd1 : thr) * 32768;
    target = (absv <= t) ? 64'sd32768 : (t * 32768) / absv;
    delayed = m_mem[m_ptr];
    m_mem[m_ptr] = dv;
    m_ptr = (m_ptr + 1) % 16;
    zero = (m_fill < 16);
    if (m_fill < 16) m_fill++;
    if (!en) begin
      m_gain = 32768;
      m_hold = 0;
    end else if (target < m_gain) begin
      m_gain = target;
      m_hold = 16;
    end else if (m_hold != 0) begin
      m_hold--;
    end else begin
      m_gain = m_gain + longint'(rel);
      if (m_gain > 32768) m_gain = 32768;
    end
    y = (delayed * m_gain + 64'sd16384) >>> 15;
    if (y > 64'sd8388607) y = 64'sd8388607;
    else if (y < -64'sd8388608) y = -64'sd8388608;
    e.data = zero ? 24'd0 : y[23:0];
    e.gain = m_gain[15:0];
    e.lim  = (m_gain < 32768);
    e.cyc  = tcyc;
    sb.push_back(e);
  endtask

  // One tick with its expectation; returns once the DUT has had time to publish it.
  task automatic applyStimulus(input logic signed [23:0] d, input logic en, input logic [7:0] thr,
                               input logic [7:0] rel);
    @(posedge clk);
    #1;
    bus.data_i        = d;
    bus.enable_i      = en;
    bus.threshold_i   = thr;
    bus.release_i     = rel;
    bus.sample_tick_i = 1'b1;
    modelPush(d, en, thr, rel, cyc + 1);
    @(posedge clk);
    #1;
    bus.sample_tick_i = 1'b0;
    repeat (21) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.sample_tick_o) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL unexpected_output: observed sample_tick_o 1 expected no output");
      end else begin
        mon_e = sb.pop_front();
        checkOutput("data_o",     24'(bus.data_o),     mon_e.data);
        checkOutput("gain_o",     24'(bus.gain_o),     24'(mon_e.gain));
        checkOutput("limiting_o", 24'(bus.limiting_o), 24'(mon_e.lim));
        checkOutput("latency",    24'(cyc - mon_e.cyc), 24'd20);
      end
    end
  end

  initial begin
    logic signed [23:0] bypass_tab [5];
    bypass_tab[0] = 24'sh7FFFFF;
    bypass_tab[1] = 24'sh800000;
    bypass_tab[2] = 24'sh123456;
    bypass_tab[3] = 24'shFFFFFF;
    bypass_tab[4] = 24'sh000000;

    bus.sample_tick_i = 1'b0;
    bus.data_i        = '0;
    bus.enable_i      = 1'b1;
    bus.threshold_i   = 8'h40;
    bus.release_i     = 8'h10;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("rst_data",     24'(bus.data_o),        24'h000000);
    checkOutput("rst_gain",     24'(bus.gain_o),        24'h008000);
    checkOutput("rst_limiting", 24'(bus.limiting_o),    24'h0);
    checkOutput("rst_overrun",  24'(bus.overrun_o),     24'h0);
    checkOutput("rst_tick",     24'(bus.sample_tick_o), 24'h0);
    rst = 1'b0;

    $display("[TB] steady level below threshold");
    for (int i = 0; i < 40; i++) applyStimulus(24'sh100000, 1'b1, 8'h40, 8'h10);
    checkOutput("steady_data", 24'(bus.data_o), 24'h100000);

    $display("[TB] attack, hold and release");
    for (int i = 0; i < 16; i++) applyStimulus(24'sh000100, 1'b1, 8'h40, 8'h10);
    applyStimulus(24'sh400000, 1'b1, 8'h40, 8'h10);
    checkOutput("attack_gain", 24'(bus.gain_o),     24'h004000);
    checkOutput("attack_lim",  24'(bus.limiting_o), 24'h1);
    checkOutput("attack_pre",  24'(bus.data_o),     24'h000080);
    for (int k = 1; k <= 1040; k++) begin
      applyStimulus(24'sh000100, 1'b1, 8'h40, 8'h10);
      if (k == 16) begin
        checkOutput("peak_out",  24'(bus.data_o), 24'h200000);
        checkOutput("hold_gain", 24'(bus.gain_o), 24'h004000);
      end
      if (k == 17) checkOutput("rel_first", 24'(bus.gain_o), 24'h004010);
      if (k == 1039) begin
        checkOutput("rel_near",     24'(bus.gain_o),     24'h007FF0);
        checkOutput("rel_near_lim", 24'(bus.limiting_o), 24'h1);
      end
    end
    checkOutput("rel_unity", 24'(bus.gain_o),     24'h008000);
    checkOutput("rel_lim",   24'(bus.limiting_o), 24'h0);

    $display("[TB] full-scale negative sample");
    for (int i = 0; i < 4; i++) applyStimulus(24'sh000100, 1'b1, 8'h7F, 8'h10);
    applyStimulus(24'sh800000, 1'b1, 8'h7F, 8'h10);
    checkOutput("sat_gain", 24'(bus.gain_o), 24'h003F80);
    for (int i = 0; i < 16; i++) applyStimulus(24'sh000100, 1'b1, 8'h7F, 8'h10);
    checkOutput("sat_out", 24'(bus.data_o), 24'hC08000);

    $display("[TB] overlapping ticks");
    @(posedge clk);
    #1;
    bus.data_i        = 24'sh000200;
    bus.threshold_i   = 8'h40;
    bus.sample_tick_i = 1'b1;
    modelPush(24'sh000200, 1'b1, 8'h40, 8'h10, cyc + 1);
    @(posedge clk);
    #1;
    bus.sample_tick_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.data_i        = 24'sh300000;
    bus.sample_tick_i = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("overrun_set", 24'(bus.overrun_o), 24'h1);
    applyStimulus(24'sh000200, 1'b1, 8'h40, 8'h10);
    checkOutput("overrun_sticky", 24'(bus.overrun_o), 24'h1);

    $display("[TB] reset during divide");
    @(posedge clk);
    #1;
    bus.data_i        = 24'sh123456;
    bus.sample_tick_i = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_data",     24'(bus.data_o),        24'h000000);
    checkOutput("mid_rst_gain",     24'(bus.gain_o),        24'h008000);
    checkOutput("mid_rst_limiting", 24'(bus.limiting_o),    24'h0);
    checkOutput("mid_rst_overrun",  24'(bus.overrun_o),     24'h0);
    checkOutput("mid_rst_tick",     24'(bus.sample_tick_o), 24'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();

    $display("[TB] refill with minimum threshold, then bypass");
    for (int i = 0; i < 20; i++) applyStimulus(24'sh010000, 1'b1, 8'h00, 8'h80);
    for (int i = 0; i < 36; i++) applyStimulus(bypass_tab[i % 5], 1'b0, 8'h01, 8'h10);
    checkOutput("bypass_gain", 24'(bus.gain_o), 24'h008000);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    checkOutput("drain_pending", 24'(sb.size()), 24'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
